// File: rtl/cpu_lsu_pkg.sv
// Shared definitions for the load/store unit: size codes, FSM encoding and
// the byte-lane helper functions used by the aligner.
package cpu_lsu_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_X = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            SZ_B:    is_misaligned = 1'b0;
            SZ_H:    is_misaligned = lo[0];
            SZ_W:    is_misaligned = (lo != 2'b00);
            default: is_misaligned = 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] be_gen(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            SZ_B:    be_gen = 4'b0001 << lo;
            SZ_H:    be_gen = lo[1] ? 4'b1100 : 4'b0011;
            default: be_gen = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_lane(input logic [1:0] size, input logic [31:0] wdata);
        case (size)
            SZ_B:    store_lane = {4{wdata[7:0]}};
            SZ_H:    store_lane = {2{wdata[15:0]}};
            default: store_lane = wdata;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [1:0] size, input logic [1:0] lo,
                                                input logic uns, input logic [31:0] rdata);
        logic [31:0] sh;
        logic [15:0] h;
        sh = rdata >> {lo, 3'b000};
        h  = lo[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            SZ_B:    load_extend = uns ? {24'd0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
            SZ_H:    load_extend = uns ? {16'd0, h} : {{16{h[15]}}, h};
            default: load_extend = rdata;
        endcase
    endfunction

endpackage

// File: rtl/cpu_lsu_align.sv
// Combinational lane logic: byte enables, store-data replication and load
// sign/zero extension. Kept separate so the data cache can reuse it.
module cpu_lsu_align
    import cpu_lsu_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  addr_lo_i,
    input  logic        unsigned_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);

    assign be_o    = be_gen(size_i, addr_lo_i);
    assign wdata_o = store_lane(size_i, wdata_i);
    assign rdata_o = load_extend(size_i, addr_lo_i, unsigned_i, rdata_i);

endmodule

// File: rtl/cpu_lsu.sv
// Memory-stage load/store unit: one pipelined-Wishbone access per request,
// with ack timeout and a one-cycle writeback pulse on completion or error.
module cpu_lsu
    import cpu_lsu_pkg::*;
#(
    parameter int ACK_TIMEOUT = 255,
    parameter int TMO_W       = 8
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        ex_valid,
    input  logic        ex_we,
    input  logic [1:0]  ex_size,
    input  logic        ex_unsigned,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_wdata,
    input  logic [4:0]  ex_rd,
    output logic        lsu_busy,
    output logic        data_cyc_out,
    output logic        data_stb_out,
    output logic        data_we_out,
    output logic [3:0]  data_be_out,
    output logic [31:0] data_addr_out,
    output logic [31:0] data_data_out,
    input  logic        data_stall_in,
    input  logic        data_ack_in,
    input  logic [31:0] data_data_in,
    output logic        wb_valid,
    output logic        wb_we_reg,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        lsu_misalign,
    output logic        lsu_timeout
);

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);

    logic [1:0]       state_q, state_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             wb_valid_q, wb_valid_d;
    logic             wb_we_q, wb_we_d;
    logic [4:0]       wb_rd_q, wb_rd_d;
    logic [31:0]      wb_data_q, wb_data_d;
    logic             misalign_q, misalign_d;
    logic             timeout_q, timeout_d;

    logic             we_q, uns_q;
    logic [1:0]       size_q;
    logic [31:0]      addr_q, wdata_q;
    logic [4:0]       rd_q;

    logic             accept, done, abort;
    logic [3:0]       be;
    logic [31:0]      lane_wdata, ext_rdata;

    cpu_lsu_align u_align (
        .size_i     (size_q),
        .addr_lo_i  (addr_q[1:0]),
        .unsigned_i (uns_q),
        .wdata_i    (wdata_q),
        .rdata_i    (data_data_in),
        .be_o       (be),
        .wdata_o    (lane_wdata),
        .rdata_o    (ext_rdata)
    );

    always_comb begin
        state_d    = state_q;
        tmo_d      = tmo_q;
        wb_valid_d = 1'b0;
        wb_we_d    = 1'b0;
        wb_rd_d    = wb_rd_q;
        wb_data_d  = wb_data_q;
        misalign_d = 1'b0;
        timeout_d  = 1'b0;
        accept     = 1'b0;
        done       = 1'b0;
        abort      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ex_valid) begin
                    if (is_misaligned(ex_size, ex_addr[1:0])) begin
                        misalign_d = 1'b1;
                        wb_valid_d = 1'b1;
                        wb_rd_d    = ex_rd;
                    end else begin
                        accept  = 1'b1;
                        state_d = ST_REQ;
                        tmo_d   = '0;
                    end
                end
            end
            ST_REQ: begin
                // An ack only counts once the strobe has actually been taken.
                if (!data_stall_in && data_ack_in) begin
                    done = 1'b1;
                end else begin
                    if (!data_stall_in) state_d = ST_WAIT;
                    abort = (tmo_q == TMO_LAST);
                end
            end
            ST_WAIT: begin
                if (data_ack_in) done = 1'b1;
                else             abort = (tmo_q == TMO_LAST);
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_q == ST_REQ || state_q == ST_WAIT) tmo_d = tmo_q + 1'b1;
        if (done) begin
            state_d    = ST_IDLE;
            wb_valid_d = 1'b1;
            wb_we_d    = !we_q;
            wb_rd_d    = rd_q;
            if (!we_q) wb_data_d = ext_rdata;
        end else if (abort) begin
            state_d    = ST_IDLE;
            wb_valid_d = 1'b1;
            timeout_d  = 1'b1;
            wb_rd_d    = rd_q;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state_q    <= ST_IDLE;
            tmo_q      <= '0;
            wb_valid_q <= 1'b0;
            wb_we_q    <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
            misalign_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            tmo_q      <= tmo_d;
            wb_valid_q <= wb_valid_d;
            wb_we_q    <= wb_we_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
            misalign_q <= misalign_d;
            timeout_q  <= timeout_d;
        end
    end

    // Request payload needs no reset: bus outputs are gated by cyc.
    always_ff @(posedge sys_clk) begin
        if (accept) begin
            we_q    <= ex_we;
            size_q  <= ex_size;
            uns_q   <= ex_unsigned;
            addr_q  <= ex_addr;
            wdata_q <= ex_wdata;
            rd_q    <= ex_rd;
        end
    end

    assign lsu_busy      = (state_q != ST_IDLE);
    assign data_cyc_out  = (state_q != ST_IDLE);
    assign data_stb_out  = (state_q == ST_REQ);
    assign data_we_out   = data_cyc_out & we_q;
    assign data_be_out   = data_cyc_out ? be : 4'b0000;
    assign data_addr_out = data_cyc_out ? {addr_q[31:2], 2'b00} : 32'd0;
    assign data_data_out = data_cyc_out ? lane_wdata : 32'd0;

    assign wb_valid     = wb_valid_q;
    assign wb_we_reg    = wb_we_q;
    assign wb_rd        = wb_rd_q;
    assign wb_data      = wb_data_q;
    assign lsu_misalign = misalign_q;
    assign lsu_timeout  = timeout_q;

endmodule
